// File: rtl/xsw_pkg.sv
// Shared switch definitions: payload field-offset helpers and the ingress burst FSM state.
// Payload layout, MSB first: dst | src | ocy | rel | body.
package xsw_pkg;

  typedef enum logic {StIdle, StBurst} xsw_fsm_e;

  function automatic int unsigned xsw_src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned xsw_body_w(input int unsigned p, input int unsigned lu_n,
                                             input int unsigned src_w);
    return p - lu_n - src_w - 2;
  endfunction

  function automatic int unsigned xsw_dst_lsb(input int unsigned p, input int unsigned lu_n);
    return p - lu_n;
  endfunction

  function automatic int unsigned xsw_src_lsb(input int unsigned p, input int unsigned lu_n,
                                              input int unsigned src_w);
    return p - lu_n - src_w;
  endfunction

  function automatic int unsigned xsw_ocy_pos(input int unsigned p, input int unsigned lu_n,
                                              input int unsigned src_w);
    return p - lu_n - src_w - 1;
  endfunction

  function automatic int unsigned xsw_rel_pos(input int unsigned p, input int unsigned lu_n,
                                              input int unsigned src_w);
    return p - lu_n - src_w - 2;
  endfunction

endpackage

// File: rtl/xsw_fifo.sv
// Registered-storage beat FIFO; head is read straight from storage so it holds until popped.
module xsw_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CntW'(1);
    else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    data_o  = empty_o ? '0 : mem_q[rptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/xsw_ingress_framer.sv
// Ingress framer: tags upstream beats with dst/src/ocy/rel and queues them toward the switch.
// Bursts are closed by in_last or by the MAX_BEATS limit (the latter pulses trunc).
module xsw_ingress_framer
  import xsw_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter int unsigned M         = 3,
  parameter int unsigned P         = 16,
  parameter int unsigned SRC_ID    = 0,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned SRC_W    = xsw_src_w(N),
  localparam int unsigned LU_N     = $clog2(M),
  localparam int unsigned BODY_W   = xsw_body_w(P, LU_N, SRC_W),
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [LU_N-1:0]   in_dst,
  input  logic              in_last,
  input  logic [BODY_W-1:0] in_body,
  output logic              vld_m,
  output logic [P-1:0]      pld_m,
  input  logic              gnt_m,
  output logic [CNT_W-1:0]  count,
  output logic              trunc
);

  localparam int unsigned BcW    = $clog2(MAX_BEATS + 1);
  localparam int unsigned DstLsb = xsw_dst_lsb(P, LU_N);
  localparam int unsigned SrcLsb = xsw_src_lsb(P, LU_N, SRC_W);
  localparam int unsigned OcyPos = xsw_ocy_pos(P, LU_N, SRC_W);
  localparam int unsigned RelPos = xsw_rel_pos(P, LU_N, SRC_W);

  xsw_fsm_e        state_q, state_d;
  logic [LU_N-1:0] dst_q, dst_d, dst;
  logic [BcW-1:0]  bcnt_q, bcnt_d, beat_n;
  logic            trunc_q, trunc_d;
  logic            push, pop, full, empty, ocy, at_max, close;
  logic [P-1:0]    pld_in;

  always_comb begin
    push    = in_vld & in_rdy;
    beat_n  = bcnt_q + BcW'(1);
    at_max  = (beat_n == BcW'(MAX_BEATS));
    close   = in_last | at_max;
    ocy     = (state_q == StIdle);
    dst     = ocy ? in_dst : dst_q;
    state_d = state_q;
    dst_d   = dst_q;
    bcnt_d  = bcnt_q;
    trunc_d = 1'b0;
    if (push) begin
      dst_d = dst;
      if (close) begin
        state_d = StIdle;
        bcnt_d  = '0;
        trunc_d = ~in_last;
      end else begin
        state_d = StBurst;
        bcnt_d  = beat_n;
      end
    end
  end

  always_comb begin
    pld_in                     = '0;
    pld_in[DstLsb +: LU_N]     = dst;
    pld_in[SrcLsb +: SRC_W]    = SRC_W'(SRC_ID);
    pld_in[OcyPos]             = ocy;
    pld_in[RelPos]             = close;
    pld_in[BODY_W-1:0]         = in_body;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      dst_q   <= '0;
      bcnt_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      bcnt_q  <= bcnt_d;
      trunc_q <= trunc_d;
    end
  end

  xsw_fifo #(
    .Width (P),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (pld_in),
    .pop_i   (pop),
    .data_o  (pld_m),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    in_rdy = ~full;
    vld_m  = ~empty;
    pop    = vld_m & gnt_m;
    trunc  = trunc_q;
  end

endmodule
